// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flop, LSB first.
// Optional signed-overflow output enabled with SERIAL_ADDER_OVF_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sp, sp_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             last, accept;

    full_adder u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_sp1
            assign sp_nxt = fa_s;
        end else begin : g_spn
            assign sp_nxt = {fa_s, sp[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT:   if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            sp    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sp    <= sp_nxt;
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= sp_nxt;
                cout <= fa_co;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the final edge the carry flop still holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst)                         ovf <= 1'b0;
        else if (state == SHIFT && last) ovf <= carry ^ fa_co;
    end
`else
    // Overflow tracking not built.
`endif

endmodule
